// File: rtl/eval_schedule_ctrl_if.sv
// Queue-side and evaluation-side signals of the evaluation schedule controller.
// The master modport is the controller's view; slave is the queue/datapath view.
interface eval_schedule_ctrl_if #(
  parameter int NUM_IN  = 1,
  parameter int NUM_OUT = 10,
  parameter int TS_W    = 64
);
  logic               q_pop_valid;
  logic [NUM_IN-1:0]  q_event_mask;
  logic [TS_W-1:0]    q_event_ts;
  logic               q_pop;
  logic [NUM_IN-1:0]  enable_in;
  logic [NUM_OUT-1:0] enable_out;
  logic [TS_W-1:0]    eval_ts;
  logic               busy;
  logic               deadline_miss;

  modport master (
    input  q_pop_valid, q_event_mask, q_event_ts,
    output q_pop, enable_in, enable_out, eval_ts, busy, deadline_miss
  );

  modport slave (
    output q_pop_valid, q_event_mask, q_event_ts,
    input  q_pop, enable_in, enable_out, eval_ts, busy, deadline_miss
  );
endinterface

// File: rtl/eval_schedule_ctrl.sv
// Sequences one evaluation (event or periodic tick) at a time through LOAD and the output layers.
// Optional macro SKIP_EMPTY_LAYERS_EN: layers without any active output are skipped.
module eval_schedule_ctrl #(
  parameter int NUM_IN        = 1,
  parameter int NUM_OUT       = 10,
  parameter int NUM_LAYERS    = 3,
  parameter int LAYER_W       = 2,
  parameter int TS_W          = 64,
  parameter int PERIOD_CYCLES = 500,
  parameter logic [NUM_OUT*LAYER_W-1:0] OUT_LAYER    = {{2{2'd3}}, {4{2'd2}}, {4{2'd1}}},
  parameter logic [NUM_OUT*NUM_IN-1:0]  OUT_TRIG     = 10'h0FF,
  parameter logic [NUM_OUT-1:0]         OUT_PERIODIC = 10'h300
) (
  input logic clk,
  input logic rst,
  input logic en,
  eval_schedule_ctrl_if.master bus
);

  localparam int TICK_W = $clog2(PERIOD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL
  } state_t;

  state_t              state, state_nxt;
  logic [LAYER_W-1:0]  layer, layer_nxt;
  logic [NUM_OUT-1:0]  active, event_active;
  logic [NUM_IN-1:0]   mask_r;
  logic                is_tick;
  logic [TS_W-1:0]     time_cnt, tick_ts, eval_ts;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick_pending, tick_wrap, deadline_miss;
  logic                start_tick, start_event;
  logic                q_pop;
  logic [NUM_IN-1:0]   enable_in;
  logic [NUM_OUT-1:0]  enable_out;

  function automatic logic [NUM_OUT-1:0] layer_mask(input logic [LAYER_W-1:0] l);
    logic [NUM_OUT-1:0] m;
    m = '0;
    for (int j = 0; j < NUM_OUT; j++)
      m[j] = (OUT_LAYER[j*LAYER_W +: LAYER_W] == l);
    return m;
  endfunction

`ifdef SKIP_EMPTY_LAYERS_EN
  // Lowest layer above 'from' that owns an active output; 0 means none left.
  function automatic logic [LAYER_W-1:0] next_active(input logic [LAYER_W-1:0] from,
                                                     input logic [NUM_OUT-1:0] act);
    logic [LAYER_W-1:0] res;
    res = '0;
    for (int l = NUM_LAYERS; l >= 1; l--)
      if ((LAYER_W'(l) > from) && ((act & layer_mask(LAYER_W'(l))) != '0))
        res = LAYER_W'(l);
    return res;
  endfunction
`endif

  always_comb begin
    event_active = '0;
    for (int j = 0; j < NUM_OUT; j++)
      event_active[j] = (|(OUT_TRIG[j*NUM_IN +: NUM_IN] & bus.q_event_mask)) & ~OUT_PERIODIC[j];
  end

  assign tick_wrap = (tick_cnt == TICK_W'(PERIOD_CYCLES - 1));

  // A new request may start in IDLE or on the final cycle of the current one, so
  // back-to-back evaluations run without an idle gap.
  always_comb begin
    state_nxt   = state;
    layer_nxt   = layer;
    start_tick  = 1'b0;
    start_event = 1'b0;
    q_pop       = 1'b0;
    enable_in   = '0;
    enable_out  = '0;
    case (state)
      S_IDLE: begin
        state_nxt = S_IDLE;
      end
      S_LOAD: begin
        q_pop     = ~is_tick;
        enable_in = mask_r;
`ifdef SKIP_EMPTY_LAYERS_EN
        layer_nxt = next_active('0, active);
        state_nxt = (layer_nxt == '0) ? S_IDLE : S_EVAL;
`else
        layer_nxt = LAYER_W'(1);
        state_nxt = S_EVAL;
`endif
      end
      S_EVAL: begin
        enable_out = active & layer_mask(layer);
`ifdef SKIP_EMPTY_LAYERS_EN
        layer_nxt = next_active(layer, active);
        state_nxt = (layer_nxt == '0) ? S_IDLE : S_EVAL;
`else
        if (layer == LAYER_W'(NUM_LAYERS)) begin
          layer_nxt = '0;
          state_nxt = S_IDLE;
        end else begin
          layer_nxt = layer + LAYER_W'(1);
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt == S_IDLE) begin
      if (tick_pending) begin
        start_tick = 1'b1;
        state_nxt  = S_LOAD;
      end else if (bus.q_pop_valid) begin
        start_event = 1'b1;
        state_nxt   = S_LOAD;
      end
    end
    if (!en) begin
      q_pop      = 1'b0;
      enable_in  = '0;
      enable_out = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      layer         <= '0;
      active        <= '0;
      mask_r        <= '0;
      is_tick       <= 1'b0;
      time_cnt      <= '0;
      tick_ts       <= '0;
      eval_ts       <= '0;
      tick_cnt      <= '0;
      tick_pending  <= 1'b0;
      deadline_miss <= 1'b0;
    end else if (en) begin
      time_cnt <= time_cnt + TS_W'(1);
      tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
      if (tick_wrap) begin
        tick_pending <= 1'b1;
        tick_ts      <= time_cnt;
        if (tick_pending)
          deadline_miss <= 1'b1;
      end else if (start_tick) begin
        tick_pending <= 1'b0;
      end
      state <= state_nxt;
      layer <= layer_nxt;
      // The tick timestamp is taken before any same-cycle overwrite by a new wrap.
      if (start_tick) begin
        is_tick <= 1'b1;
        active  <= OUT_PERIODIC;
        mask_r  <= '0;
        eval_ts <= tick_ts;
      end else if (start_event) begin
        is_tick <= 1'b0;
        active  <= event_active;
        mask_r  <= bus.q_event_mask;
        eval_ts <= bus.q_event_ts;
      end
    end
  end

  assign bus.q_pop         = q_pop;
  assign bus.enable_in     = enable_in;
  assign bus.enable_out    = enable_out;
  assign bus.eval_ts       = eval_ts;
  assign bus.busy          = (state != S_IDLE);
  assign bus.deadline_miss = deadline_miss;

endmodule

// File: tb/tb_eval_schedule_ctrl.sv
// Bench for eval_schedule_ctrl: two instances (long and very short tick period) checked
// every cycle against a schedule-list reference model.
module tb_eval_schedule_ctrl;

  localparam int NUM_OUT = 10;
  localparam logic [19:0] OUT_LAYER    = {{2{2'd3}}, {4{2'd2}}, {4{2'd1}}};
  localparam logic [9:0]  OUT_TRIG     = 10'h0FF;
  localparam logic [9:0]  OUT_PERIODIC = 10'h300;
`ifdef SKIP_EMPTY_LAYERS_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int EVENT_LAT = SKIP ? 3 : 4;
  localparam int TICK_LAT  = SKIP ? 2 : 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        valid;
  logic        mask;
  logic [63:0] ts;
  int          checks;
  int          failures;

  always #5 clk = ~clk;

  eval_schedule_ctrl_if #(.NUM_IN(1), .NUM_OUT(10), .TS_W(64)) if0 ();
  eval_schedule_ctrl_if #(.NUM_IN(1), .NUM_OUT(10), .TS_W(64)) if1 ();

  assign if0.q_pop_valid  = valid;
  assign if0.q_event_mask = mask;
  assign if0.q_event_ts   = ts;
  assign if1.q_pop_valid  = valid;
  assign if1.q_event_mask = mask;
  assign if1.q_event_ts   = ts;

  eval_schedule_ctrl #(.PERIOD_CYCLES(500)) dut0 (.clk(clk), .rst(rst), .en(en), .bus(if0.master));
  eval_schedule_ctrl #(.PERIOD_CYCLES(3))   dut1 (.clk(clk), .rst(rst), .en(en), .bus(if1.master));

  // Reference model: per instance, a list of the outputs each remaining cycle must show.
  logic [63:0] m_time [2];
  logic [63:0] m_tick_ts [2];
  logic [63:0] m_eval_ts [2];
  int          m_tick_cnt [2];
  bit          m_pending [2];
  bit          m_miss [2];
  int          m_len [2];
  int          m_pos [2];
  bit          s_pop [2][4];
  logic        s_in [2][4];
  logic [9:0]  s_out [2][4];

  function automatic int period(input int k);
    return (k == 0) ? 500 : 3;
  endfunction

  task automatic reset_model(input int k);
    m_time[k] = '0; m_tick_ts[k] = '0; m_eval_ts[k] = '0;
    m_tick_cnt[k] = 0; m_pending[k] = 0; m_miss[k] = 0;
    m_len[k] = 0; m_pos[k] = 0;
  endtask

  task automatic build_schedule(input int k, input bit tick, input logic m);
    logic [9:0] act, lay;
    int n;
    for (int j = 0; j < NUM_OUT; j++)
      act[j] = tick ? OUT_PERIODIC[j] : (OUT_TRIG[j] & m & ~OUT_PERIODIC[j]);
    s_pop[k][0] = !tick;
    s_in[k][0]  = tick ? 1'b0 : m;
    s_out[k][0] = '0;
    n = 1;
    for (int l = 1; l <= 3; l++) begin
      lay = '0;
      for (int j = 0; j < NUM_OUT; j++)
        if (int'(OUT_LAYER[j*2 +: 2]) == l && act[j]) lay[j] = 1'b1;
      if (!SKIP || lay != '0) begin
        s_pop[k][n] = 1'b0; s_in[k][n] = 1'b0; s_out[k][n] = lay;
        n++;
      end
    end
    m_len[k] = n;
    m_pos[k] = 0;
  endtask

  task automatic step_model(input int k);
    bit wrap, began_tick;
    if (rst !== 1'b1) begin
      reset_model(k);
      return;
    end
    if (en !== 1'b1) return;
    wrap = (m_tick_cnt[k] == period(k) - 1);
    began_tick = 0;
    if (m_pos[k] < m_len[k]) m_pos[k]++;
    if (m_pos[k] >= m_len[k]) begin
      if (m_pending[k]) begin
        build_schedule(k, 1'b1, 1'b0);
        m_eval_ts[k] = m_tick_ts[k];
        began_tick = 1;
      end else if (valid) begin
        build_schedule(k, 1'b0, mask);
        m_eval_ts[k] = ts;
      end
    end
    if (wrap) begin
      if (m_pending[k]) m_miss[k] = 1;
      m_pending[k] = 1;
      m_tick_ts[k] = m_time[k];
    end else if (began_tick) begin
      m_pending[k] = 0;
    end
    m_tick_cnt[k] = wrap ? 0 : m_tick_cnt[k] + 1;
    m_time[k] = m_time[k] + 64'd1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_inst(input int k, input logic pop, input logic ein, input logic [9:0] eout,
                            input logic [63:0] ets, input logic bsy, input logic miss);
    bit act, live;
    int p;
    act  = (m_pos[k] < m_len[k]);
    p    = act ? m_pos[k] : 0;
    live = act && (en === 1'b1);
    checkOutput($sformatf("i%0d_q_pop", k),      64'(pop),  live ? 64'(s_pop[k][p]) : 64'd0);
    checkOutput($sformatf("i%0d_enable_in", k),  64'(ein),  live ? 64'(s_in[k][p])  : 64'd0);
    checkOutput($sformatf("i%0d_enable_out", k), 64'(eout), live ? 64'(s_out[k][p]) : 64'd0);
    checkOutput($sformatf("i%0d_eval_ts", k),    ets,       m_eval_ts[k]);
    checkOutput($sformatf("i%0d_busy", k),       64'(bsy),  64'(act));
    checkOutput($sformatf("i%0d_deadline", k),   64'(miss), 64'(m_miss[k]));
  endtask

  task automatic check_all();
    check_inst(0, if0.q_pop, if0.enable_in[0], if0.enable_out, if0.eval_ts, if0.busy, if0.deadline_miss);
    check_inst(1, if1.q_pop, if1.enable_in[0], if1.enable_out, if1.eval_ts, if1.busy, if1.deadline_miss);
  endtask

  task automatic applyStimulus(input logic e, input logic v, input logic m, input logic [63:0] t);
    en = e; valid = v; mask = m; ts = t;
  endtask

  task automatic step_edge();
    @(posedge clk);
    step_model(0);
    step_model(1);
    #1;
  endtask

  task automatic check_phase();
    @(negedge clk);
    check_all();
  endtask

  task automatic cyc(input logic e, input logic v, input logic m, input logic [63:0] t);
    step_edge();
    applyStimulus(e, v, m, t);
    check_phase();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pops, last, n;
    bit found;
    logic [9:0] exp_out [3];
    checks = 0; failures = 0;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
    reset_model(0); reset_model(1);

    // Inputs active during reset must have no effect.
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 64'd5);
    step_edge(); rst = 1'b1; applyStimulus(1'b1, 1'b0, 1'b0, 64'd0); check_phase();
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 64'd0);

    $display("[TB] single event walk-through");
    exp_out[0] = 10'h00F; exp_out[1] = 10'h0F0; exp_out[2] = 10'h000;
    cyc(1'b1, 1'b1, 1'b1, 64'd1000);
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    checkOutput("walk_q_pop", 64'(if0.q_pop), 64'd1);
    checkOutput("walk_enable_in", 64'(if0.enable_in), 64'd1);
    checkOutput("walk_eval_ts", if0.eval_ts, 64'd1000);
    for (int i = 0; i < EVENT_LAT - 1; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 64'd0);
      checkOutput($sformatf("walk_layer%0d_out", i + 1), 64'(if0.enable_out), 64'(exp_out[i]));
    end
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    checkOutput("walk_busy_end", 64'(if0.busy), 64'd0);

    $display("[TB] back-to-back event burst");
    pops = 0; last = -1;
    for (int c = 0; c < 40 && pops < 4; c++) begin
      cyc(1'b1, 1'b1, 1'b1, {$urandom, $urandom});
      if (if0.q_pop === 1'b1) begin
        if (last >= 0) checkOutput("burst_pop_gap", 64'(c - last), 64'(EVENT_LAT));
        last = c;
        pops++;
      end
    end
    checkOutput("burst_reached_4", 64'(pops), 64'd4);
    repeat (10) begin
      cyc(1'b1, 1'b0, 1'b0, 64'd0);
      if (if0.q_pop === 1'b1) pops++;
    end
    checkOutput("burst_pop_count", 64'(pops), 64'd4);

    $display("[TB] idle until first long-period tick, then tick/event collision");
    found = 0;
    for (int c = 0; c < 600; c++) begin
      step_edge();
      applyStimulus(1'b1, m_pending[0], 1'b1, 64'h77);
      check_phase();
      if (m_pending[0]) begin found = 1; break; end
    end
    checkOutput("tick_wait_bound", 64'(found), 64'd1);
    n = 0;
    for (int c = 1; c <= 12; c++) begin
      cyc(1'b1, 1'b1, 1'b1, 64'h77);
      if (if0.q_pop === 1'b1) begin n = c; break; end
    end
    checkOutput("tick_then_event_gap", 64'(n), 64'(1 + TICK_LAT));
    repeat (6) cyc(1'b1, 1'b0, 1'b0, 64'd0);

    $display("[TB] clock-enable freeze mid evaluation");
    cyc(1'b1, 1'b1, 1'b1, 64'hABC);
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    repeat (5) begin
      cyc(1'b0, 1'b0, 1'b0, 64'd0);
      checkOutput("freeze_enable_out", 64'(if0.enable_out), 64'd0);
      checkOutput("freeze_q_pop", 64'(if0.q_pop), 64'd0);
    end
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 64'd0);

    $display("[TB] randomized traffic");
    repeat (600)
      cyc(($urandom % 8) != 0, ($urandom % 4) != 0, 1'($urandom % 2), {$urandom, $urandom});

    repeat (40) cyc(1'b1, 1'b1, 1'b1, {$urandom, $urandom});
    checkOutput("i1_deadline_sticky", 64'(if1.deadline_miss), 64'd1);

    $display("[TB] asynchronous reset mid evaluation");
    found = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(1'b1, 1'b0, 1'b0, 64'd0);
      if (m_pos[0] >= m_len[0]) begin found = 1; break; end
    end
    checkOutput("idle_wait_bound", 64'(found), 64'd1);
    cyc(1'b1, 1'b1, 1'b1, 64'h5555);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 64'd0);
    #2 rst = 1'b0;
    reset_model(0); reset_model(1);
    #1;
    check_all();
    checkOutput("async_rst_enable_out", 64'(if0.enable_out), 64'd0);
    checkOutput("async_rst_busy", 64'(if0.busy), 64'd0);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 64'd0);
    step_edge(); rst = 1'b1; applyStimulus(1'b1, 1'b0, 1'b0, 64'd0); check_phase();
    cyc(1'b1, 1'b1, 1'b1, 64'h1234);
    pops = 0;
    repeat (8) begin
      cyc(1'b1, 1'b0, 1'b0, 64'd0);
      if (if0.q_pop === 1'b1) pops++;
    end
    checkOutput("post_reset_pop_count", 64'(pops), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
